// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and a single-cycle instruction memory.
// An ack in a cycle with req=1 returns rdata for that same cycle's addr.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register, single-entry stall buffer and
// delay-slot branch redirect resolved from the instruction held in ID.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_rst,
  input  logic              if_en,
  input  logic [2:0]        pc_src,
  input  logic [31:0]       rs_data,
  input  logic [31:0]       rt_data,
  if_stage_if.master        imem,
  output logic [31:0]       inst_id,
  output logic [31:0]       pc4_id,
  output logic              if_valid,
  output logic              fetch_wait
);

  localparam logic [2:0] SrcJump = 3'd1;
  localparam logic [2:0] SrcJr   = 3'd2;
  localparam logic [2:0] SrcBeq  = 3'd3;
  localparam logic [2:0] SrcBne  = 3'd4;

  typedef enum logic {StFetch, StHold} state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst_id;
  logic [31:0] r_pc4_id;
  logic        r_if_valid;
  logic        r_pend;
  logic [31:0] r_pend_target;
  logic [31:0] r_buf_inst;
  logic [31:0] r_buf_pc4;

  state_e      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_inst_nxt;
  logic [31:0] w_pc4_nxt;
  logic        w_valid_nxt;
  logic        w_pend_nxt;
  logic [31:0] w_pend_target_nxt;
  logic [31:0] w_buf_inst_nxt;
  logic [31:0] w_buf_pc4_nxt;

  logic        w_accept;
  logic        w_cond;
  logic        w_taken;
  logic [31:0] w_target;
  logic [31:0] w_br_off;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_br_off   = {{14{r_inst_id[15]}}, r_inst_id[15:0], 2'b00};

  // Redirect is decided by the instruction sitting in ID, only when it is consumed.
  always_comb begin
    w_cond   = 1'b0;
    w_target = 32'h0;
    case (pc_src)
      SrcJump: begin
        w_cond   = 1'b1;
        w_target = {r_pc4_id[31:28], r_inst_id[25:0], 2'b00};
      end
      SrcJr: begin
        w_cond   = 1'b1;
        w_target = rs_data;
      end
      SrcBeq: begin
        w_cond   = (rs_data == rt_data);
        w_target = r_pc4_id + w_br_off;
      end
      SrcBne: begin
        w_cond   = (rs_data != rt_data);
        w_target = r_pc4_id + w_br_off;
      end
      default: begin
        w_cond   = 1'b0;
        w_target = 32'h0;
      end
    endcase
  end

  assign w_taken   = r_if_valid & if_en & w_cond;
  assign w_next_pc = w_taken ? w_target : (r_pend ? r_pend_target : w_pc_plus4);

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_inst_nxt        = r_inst_id;
    w_pc4_nxt         = r_pc4_id;
    w_valid_nxt       = r_if_valid;
    w_pend_nxt        = r_pend;
    w_pend_target_nxt = r_pend_target;
    w_buf_inst_nxt    = r_buf_inst;
    w_buf_pc4_nxt     = r_buf_pc4;
    w_accept          = 1'b0;

    if (if_rst) begin
      w_state_nxt       = StFetch;
      w_pc_nxt          = RESET_PC;
      w_inst_nxt        = 32'h0;
      w_pc4_nxt         = 32'h0;
      w_valid_nxt       = 1'b0;
      w_pend_nxt        = 1'b0;
      w_pend_target_nxt = 32'h0;
      w_buf_inst_nxt    = 32'h0;
      w_buf_pc4_nxt     = 32'h0;
    end else begin
      unique case (r_state)
        StFetch: begin
          if (imem.imem_ack) begin
            if (if_en) begin
              w_inst_nxt  = imem.imem_rdata;
              w_pc4_nxt   = w_pc_plus4;
              w_valid_nxt = 1'b1;
              w_accept    = 1'b1;
            end else begin
              w_buf_inst_nxt = imem.imem_rdata;
              w_buf_pc4_nxt  = w_pc_plus4;
              w_state_nxt    = StHold;
            end
          end else if (if_en) begin
            w_inst_nxt  = 32'h0;
            w_valid_nxt = 1'b0;
          end
        end
        StHold: begin
          if (if_en) begin
            w_inst_nxt  = r_buf_inst;
            w_pc4_nxt   = r_buf_pc4;
            w_valid_nxt = 1'b1;
            w_accept    = 1'b1;
            w_state_nxt = StFetch;
          end
        end
        default: w_state_nxt = StFetch;
      endcase

      // A redirect with no delay-slot word accepted is remembered until the slot arrives.
      if (w_accept) begin
        w_pc_nxt   = w_next_pc;
        w_pend_nxt = 1'b0;
      end else if (w_taken) begin
        w_pend_nxt        = 1'b1;
        w_pend_target_nxt = w_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= StFetch;
      r_pc          <= RESET_PC;
      r_inst_id     <= 32'h0;
      r_pc4_id      <= 32'h0;
      r_if_valid    <= 1'b0;
      r_pend        <= 1'b0;
      r_pend_target <= 32'h0;
      r_buf_inst    <= 32'h0;
      r_buf_pc4     <= 32'h0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_inst_id     <= w_inst_nxt;
      r_pc4_id      <= w_pc4_nxt;
      r_if_valid    <= w_valid_nxt;
      r_pend        <= w_pend_nxt;
      r_pend_target <= w_pend_target_nxt;
      r_buf_inst    <= w_buf_inst_nxt;
      r_buf_pc4     <= w_buf_pc4_nxt;
    end
  end

  // Request is suppressed combinationally so it drops the instant reset asserts.
  assign imem.imem_req  = (r_state == StFetch) & rst;
  assign imem.imem_addr = r_pc;
  assign fetch_wait     = imem.imem_req & ~imem.imem_ack;

  assign inst_id  = r_inst_id;
  assign pc4_id   = r_pc4_id;
  assign if_valid = r_if_valid;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset and on if_rst.
REQ-002 clk  in  1  main clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 if_rst  in  1  synchronous stage reinitialise from controller.
REQ-005 if_en  in  1  stage enable from controller; 1 = IF/ID register may advance.
REQ-006 pc_src  in  3  next-PC kind for the instruction in ID: 0 NEXT, 1 JUMP, 2 JR, 3 BEQ, 4 BNE, others treated as NEXT.
REQ-007 rs_data, rt_data  in  32 each  register operands of the ID instruction.
REQ-008 imem_req  out  1  instruction memory request.
REQ-009 imem_addr  out  32  fetch address (word aligned).
REQ-010 imem_ack  in  1  response valid; meaningful only while imem_req=1.
REQ-011 imem_rdata  in  32  instruction word, valid with imem_ack.
REQ-012 inst_id  out  32  IF/ID instruction register.
REQ-013 pc4_id  out  32  IF/ID PC+4 of inst_id.
REQ-014 if_valid  out  1  inst_id holds a real instruction.
REQ-015 fetch_wait  out  1  fetch outstanding and not acknowledged this cycle.

Function
REQ-016 State machine has two states: FETCH (imem_req=1) and HOLD (imem_req=0, fetched word buffered).
REQ-017 imem_addr SHALL equal internal pc register; protocol is single-cycle: ack in a cycle with req=1 returns rdata for that cycle's address; req/addr may change any cycle, no response outstanding across cycles.
REQ-018 FETCH, ack=1, if_en=1: inst_id<=rdata, pc4_id<=pc+4, if_valid<=1, pc<=next_pc, stay FETCH.
REQ-019 FETCH, ack=1, if_en=0: rdata and pc+4 captured in hold buffer, IF/ID unchanged, go HOLD.
REQ-020 FETCH, ack=0, if_en=1: bubble into ID: inst_id<=0, if_valid<=0, pc4_id unchanged, pc unchanged.
REQ-021 FETCH, ack=0, if_en=0: no state change.
REQ-022 HOLD, if_en=1: buffer moves to IF/ID (if_valid<=1), pc<=next_pc, go FETCH; HOLD, if_en=0: no change.
REQ-023 taken = if_valid & if_en & (pc_src==JUMP | pc_src==JR | (pc_src==BEQ & rs_data==rt_data) | (pc_src==BNE & rs_data!=rt_data)).
REQ-024 Targets: JUMP {pc4_id[31:28], inst_id[25:0], 2'b00}; JR rs_data; BEQ/BNE pc4_id + (sign-extended inst_id[15:0] << 2), 32-bit wrap-around.
REQ-025 Delay-slot semantics: the instruction at branch PC+4 is always delivered; redirect applies to the PC after it.
REQ-026 next_pc = taken ? target : pend ? pend_target : pc+4 (32-bit wrap).
REQ-027 If taken and no word accepted into ID this cycle, pend<=1, pend_target<=target; pend cleared when next_pc is consumed (REQ-018/022).
REQ-028 taken while pend=1 SHALL overwrite pend_target (latest wins).
REQ-029 fetch_wait = (state==FETCH) & ~imem_ack; 0 in HOLD.
REQ-030 if_rst=1 (priority over all of REQ-018..028): pc<=RESET_PC, inst_id<=0, pc4_id<=0, if_valid<=0, pend<=0, buffer cleared, state<=FETCH; any ack that cycle discarded.

Reset
REQ-031 rst low asynchronously forces pc=RESET_PC, inst_id=0, pc4_id=0, if_valid=0, pend=0, pend_target=0, state=FETCH.
REQ-032 imem_req SHALL be 0 while rst low; first request (addr RESET_PC) in first cycle after release.
REQ-033 Reset asserted mid-HOLD or mid-pend SHALL discard buffer and pending target.

Verification
REQ-034 Zero-wait memory, if_en=1, 3 words: inst_id sequence addr 0,4,8 on consecutive cycles, pc4_id 4,8,12, if_valid=1 from cycle 1.
REQ-035 Ack withheld 2 cycles at addr 4, if_en=1: two bubbles (if_valid=0, inst_id=0), fetch_wait=1 both cycles, imem_addr stays 4.
REQ-036 Ack at addr 8 with if_en=0 for 3 cycles: state HOLD, imem_req=0, IF/ID frozen; if_en=1 -> inst_id=word@8, fetch resumes at 12.
REQ-037 inst_id=J 0x40 (pc4_id=0x14) with delay-slot ack same cycle: next delivered is word@0x14, next fetch addr 0x40; repeat with delay slot delayed 2 cycles -> pend=1, same result.
REQ-038 BEQ offset 0xFFFF at pc4_id=0x20, rs=rt=5: target 0x1C; rs=5, rt=6: fall-through; BNE inverse; JR rs=0x100 -> 0x100.
REQ-039 if_rst pulse during HOLD with pend=1: next cycle addr=RESET_PC, if_valid=0, pend=0; rst low mid-fetch -> imem_req=0 immediately.
